// File: rtl/reg_file_pkg.sv
// Shared defaults for the multiport register file and its storage words.
// No ports; the top imports this package for its parameter defaults.
package reg_file_pkg;

  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefDepth   = 16;
  localparam bit          DefBypass  = 1'b1;
  localparam bit          DefZeroReg = 1'b1;

endpackage : reg_file_pkg

// File: rtl/reg_word.sv
// One register-file entry: a WIDTH-bit data register plus a "written since
// reset" flag. Pure storage; read muxing and forwarding live in the top.
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, clears data and flag
//   we      - load strobe (already qualified by the top)
//   d       - data to load
//   q       - stored data
//   written - set on the first load after reset
module reg_word #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             written
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      written <= 1'b0;
    end else if (we) begin
      q       <= d;
      written <= 1'b1;
    end
  end

endmodule : reg_word

// File: rtl/multiport_reg_file.sv
// Register file with one write port and two combinational read ports.
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   WriteEnable/waddr/wdata - write port; out-of-range addresses are dropped
//   ReadEnable1/2, raddr1/2 - read ports
//   rdata1/2, rvalid1/2     - read data and "entry written since reset";
//                             both zero when disabled, out of range, in reset,
//                             or addressing entry 0 with ZERO_REG set
// BYPASS forwards a committing write to same-cycle reads of that address.
module multiport_reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter bit          BYPASS   = DefBypass,
  parameter bit          ZERO_REG = DefZeroReg,
  localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ReadEnable1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              ReadEnable2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic              rvalid1,
  output logic [WIDTH-1:0]  rdata2,
  output logic              rvalid2
);

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] word_written;
  logic [DEPTH-1:0] word_we;

  logic waddr_ok;
  logic wr_commit;

  assign waddr_ok = 32'(waddr) < DEPTH;

  // A write that will actually land this edge; also the bypass qualifier, so
  // suppressed entry-0 writes and writes during reset never forward.
  assign wr_commit = WriteEnable & ~rst & waddr_ok & ~(ZERO_REG & (waddr == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word_we[i] = wr_commit & (waddr == ADDR_W'(i));

    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk     (clk),
      .rst     (rst),
      .we      (word_we[i]),
      .d       (wdata),
      .q       (word_q[i]),
      .written (word_written[i])
    );
  end

  logic              ren     [2];
  logic [ADDR_W-1:0] raddr   [2];
  logic [WIDTH-1:0]  rdata_c [2];
  logic              rvalid_c[2];

  assign ren[0]   = ReadEnable1;
  assign ren[1]   = ReadEnable2;
  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_c[p]  = '0;
      rvalid_c[p] = 1'b0;
      if (!rst && ren[p] && (32'(raddr[p]) < DEPTH) && !(ZERO_REG && (raddr[p] == '0))) begin
        if (BYPASS && wr_commit && (waddr == raddr[p])) begin
          rdata_c[p]  = wdata;
          rvalid_c[p] = 1'b1;
        end else begin
          rdata_c[p]  = word_q[raddr[p]];
          rvalid_c[p] = word_written[raddr[p]];
        end
      end
    end
  end

  assign rdata1  = rdata_c[0];
  assign rvalid1 = rvalid_c[0];
  assign rdata2  = rdata_c[1];
  assign rvalid2 = rvalid_c[1];

endmodule : multiport_reg_file

// File: tb/tb_multiport_reg_file.sv
// Bench for multiport_reg_file: instance a uses package defaults (DEPTH 16,
// bypass, zero register); instance b uses DEPTH 10, no bypass, no zero
// register. Both share one stimulus stream and are compared to an array model.
module tb_multiport_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WriteEnable = 1'b0;
  logic [3:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        ReadEnable1 = 1'b0;
  logic [3:0]  raddr1 = '0;
  logic        ReadEnable2 = 1'b0;
  logic [3:0]  raddr2 = '0;

  logic [15:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
  logic        rvalid1_a, rvalid2_a, rvalid1_b, rvalid2_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multiport_reg_file u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .WriteEnable (WriteEnable),
    .waddr       (waddr),
    .wdata       (wdata),
    .ReadEnable1 (ReadEnable1),
    .raddr1      (raddr1),
    .ReadEnable2 (ReadEnable2),
    .raddr2      (raddr2),
    .rdata1      (rdata1_a),
    .rvalid1     (rvalid1_a),
    .rdata2      (rdata2_a),
    .rvalid2     (rvalid2_a)
  );

  multiport_reg_file #(
    .WIDTH    (16),
    .DEPTH    (10),
    .BYPASS   (1'b0),
    .ZERO_REG (1'b0)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .WriteEnable (WriteEnable),
    .waddr       (waddr),
    .wdata       (wdata),
    .ReadEnable1 (ReadEnable1),
    .raddr1      (raddr1),
    .ReadEnable2 (ReadEnable2),
    .raddr2      (raddr2),
    .rdata1      (rdata1_b),
    .rvalid1     (rvalid1_b),
    .rdata2      (rdata2_b),
    .rvalid2     (rvalid2_b)
  );

  // Reference model: contents and written flags per instance.
  int unsigned depth_c [2] = '{16, 10};
  bit          byp_c   [2] = '{1'b1, 1'b0};
  bit          zr_c    [2] = '{1'b1, 1'b0};
  logic [15:0] m_data  [2][16];
  bit          m_wr    [2][16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit wr_ok(int inst);
    return WriteEnable && !rst && (int'(waddr) < int'(depth_c[inst])) &&
           !(zr_c[inst] && waddr == 4'd0);
  endfunction

  // {valid, data} a read port should show this cycle.
  function automatic logic [16:0] model_rd(int inst, logic en, logic [3:0] a);
    if (rst || !en || int'(a) >= int'(depth_c[inst]) || (zr_c[inst] && a == 4'd0))
      return 17'd0;
    if (byp_c[inst] && wr_ok(inst) && waddr == a) return {1'b1, wdata};
    return {m_wr[inst][a], m_data[inst][a]};
  endfunction

  task automatic drive(input logic r, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic re1, input logic [3:0] ra1,
                       input logic re2, input logic [3:0] ra2);
    rst = r; WriteEnable = we; waddr = wa; wdata = wd;
    ReadEnable1 = re1; raddr1 = ra1; ReadEnable2 = re2; raddr2 = ra2;
  endtask

  task automatic check_all();
    check_eq("a_port1", {15'd0, rvalid1_a, rdata1_a}, {15'd0, model_rd(0, ReadEnable1, raddr1)});
    check_eq("a_port2", {15'd0, rvalid2_a, rdata2_a}, {15'd0, model_rd(0, ReadEnable2, raddr2)});
    check_eq("b_port1", {15'd0, rvalid1_b, rdata1_b}, {15'd0, model_rd(1, ReadEnable1, raddr1)});
    check_eq("b_port2", {15'd0, rvalid2_b, rdata2_b}, {15'd0, model_rd(1, ReadEnable2, raddr2)});
  endtask

  task automatic tick();
    @(posedge clk);
    for (int inst = 0; inst < 2; inst++) begin
      if (rst) begin
        for (int e = 0; e < 16; e++) begin
          m_data[inst][e] = '0;
          m_wr[inst][e]   = 1'b0;
        end
      end else if (wr_ok(inst)) begin
        m_data[inst][waddr] = wdata;
        m_wr[inst][waddr]   = 1'b1;
      end
    end
    #1;
  endtask

  task automatic step(input logic r, input logic we, input logic [3:0] wa,
                      input logic [15:0] wd, input logic re1, input logic [3:0] ra1,
                      input logic re2, input logic [3:0] ra2);
    drive(r, we, wa, wd, re1, ra1, re2, ra2);
    @(negedge clk);
    check_all();
    tick();
  endtask

  initial begin
    for (int inst = 0; inst < 2; inst++)
      for (int e = 0; e < 16; e++) begin
        m_data[inst][e] = '0;
        m_wr[inst][e]   = 1'b0;
      end

    // Reset with everything enabled: outputs forced low.
    drive(1'b1, 1'b1, 4'd3, 16'hFFFF, 1'b1, 4'd3, 1'b1, 4'd5);
    @(negedge clk);
    check_eq("rst_rdata1", {16'd0, rdata1_a}, 32'h0);
    check_eq("rst_rvalid2", {31'd0, rvalid2_a}, 32'h0);
    check_all();
    tick();
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0);

    // Write entry 3, read it next cycle; entry 4 untouched.
    step(1'b0, 1'b1, 4'd3, 16'hA5A5, 1'b0, 4'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b1, 4'd4);
    @(negedge clk);
    check_eq("wr3_rdata1", {16'd0, rdata1_a}, 32'hA5A5);
    check_eq("wr3_rvalid1", {31'd0, rvalid1_a}, 32'h1);
    check_eq("rd4_rdata2", {16'd0, rdata2_a}, 32'h0);
    check_eq("rd4_rvalid2", {31'd0, rvalid2_a}, 32'h0);
    check_all();
    tick();

    // Same-cycle write/read of entry 5: a forwards, b shows the old value.
    drive(1'b0, 1'b1, 4'd5, 16'h1234, 1'b1, 4'd5, 1'b1, 4'd5);
    @(negedge clk);
    check_eq("byp_a_rdata1", {16'd0, rdata1_a}, 32'h1234);
    check_eq("byp_a_rdata2", {16'd0, rdata2_a}, 32'h1234);
    check_eq("nobyp_b_rdata1", {16'd0, rdata1_b}, 32'h0);
    check_all();
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 1'b1, 4'd5);
    @(negedge clk);
    check_eq("nobyp_b_next", {16'd0, rdata1_b}, 32'h1234);
    check_all();
    tick();

    // Entry 0: hardwired zero in a, ordinary storage in b.
    step(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b1, 4'd0);
    @(negedge clk);
    check_eq("zr_a_rdata1", {16'd0, rdata1_a}, 32'h0);
    check_eq("zr_a_rvalid1", {31'd0, rvalid1_a}, 32'h0);
    check_eq("nozr_b_rdata1", {16'd0, rdata1_b}, 32'hFFFF);
    check_all();
    tick();

    // Reset beats a same-cycle write to entry 7.
    step(1'b0, 1'b1, 4'd7, 16'h00FF, 1'b0, 4'd0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 4'd7, 16'hBEEF, 1'b1, 4'd7, 1'b1, 4'd7);
    @(negedge clk);
    check_eq("rstwr_rdata1", {16'd0, rdata1_a}, 32'h0);
    check_all();
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b1, 4'd7);
    @(negedge clk);
    check_eq("rstwr_after_rd", {15'd0, rvalid1_a, rdata1_a}, 32'h0);
    check_all();
    tick();

    // Out-of-range write for b (DEPTH 10); in range for a.
    for (int e = 1; e < 10; e++) step(1'b0, 1'b1, 4'(e), 16'(e * 16'h1111), 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd12, 16'h5555, 1'b0, 4'd0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd12, 1'b1, 4'd12);
    @(negedge clk);
    check_eq("oor_b_rdata1", {15'd0, rvalid1_b, rdata1_b}, 32'h0);
    check_eq("oor_a_rdata1", {16'd0, rdata1_a}, 32'h5555);
    check_all();
    tick();
    for (int e = 1; e < 10; e++) begin
      drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'(e), 1'b1, 4'(10 - e));
      @(negedge clk);
      check_eq("oor_b_keep", {16'd0, rdata1_b}, 32'(e * 16'h1111));
      check_all();
      tick();
    end

    // Read enable gating on a written entry.
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd3, 1'b0, 4'd3);
    @(negedge clk);
    check_eq("ren0_rdata1", {15'd0, rvalid1_a, rdata1_a}, 32'h0);
    check_all();
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd3);
    @(negedge clk);
    check_eq("ren1_rdata1", {15'd0, rvalid1_a, rdata1_a}, 32'h13333);
    check_all();
    tick();

    // Random traffic, occasional resets, biased toward read-after-write hits.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] wa;
      logic [3:0] ra1;
      logic [3:0] ra2;
      wa  = 4'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), wa,
           16'($urandom), ($urandom_range(0, 3) != 0), ra1,
           ($urandom_range(0, 3) != 0), ra2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_multiport_reg_file
